// File: rtl/dice_pkg.sv
// Shared constants for the dice 7-segment bus: face patterns, face width and
// the settle-tracker FSM states.
package dice_pkg;

  localparam int FACE_W = 3;

  // Bus order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_FACE1 = 7'b0000110;
  localparam logic [6:0] SEG_FACE2 = 7'b1011011;
  localparam logic [6:0] SEG_FACE3 = 7'b1001111;
  localparam logic [6:0] SEG_FACE4 = 7'b1100110;
  localparam logic [6:0] SEG_FACE5 = 7'b1101101;
  localparam logic [6:0] SEG_FACE6 = 7'b1111101;

  typedef enum logic {
    S_TRACK = 1'b0,
    S_HELD  = 1'b1
  } state_e;

endpackage

// File: rtl/seg_to_face.sv
// Combinational decode of a 7-segment pattern to a die face 1-6.
// The face output is 0 for blank and for illegal patterns.
module seg_to_face
  import dice_pkg::*;
(
  input  logic [6:0]        seg,
  output logic              legal,
  output logic              blank,
  output logic [FACE_W-1:0] face
);

  always_comb begin
    legal = 1'b0;
    blank = 1'b0;
    face  = '0;
    case (seg)
      SEG_FACE1: begin legal = 1'b1; face = FACE_W'(1); end
      SEG_FACE2: begin legal = 1'b1; face = FACE_W'(2); end
      SEG_FACE3: begin legal = 1'b1; face = FACE_W'(3); end
      SEG_FACE4: begin legal = 1'b1; face = FACE_W'(4); end
      SEG_FACE5: begin legal = 1'b1; face = FACE_W'(5); end
      SEG_FACE6: begin legal = 1'b1; face = FACE_W'(6); end
      SEG_BLANK: blank = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/dice_seg_monitor.sv
// Receive-side checker for the dice 7-segment bus: waits for seg to settle,
// reports one legal/illegal event per settle and counts rolls.
// Define DICE_HIST_EN to build the per-face histogram behind face_sel/face_count.
module dice_seg_monitor
  import dice_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int COUNT_W       = 16,
  parameter int HIST_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         seg,
  output logic               roll_valid,
  output logic [FACE_W-1:0]  roll_value,
  output logic               roll_illegal,
  output logic [COUNT_W-1:0] roll_count,
  input  logic [2:0]         face_sel,
  output logic [HIST_W-1:0]  face_count
);

  localparam int                CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_SETTLE = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]         seg_q, seg_d;
  logic [6:0]         seg_prev_q, seg_prev_d;
  logic [CNT_W-1:0]   stab_cnt_q, stab_cnt_d;
  state_e             state_q, state_d;
  logic               roll_valid_q, roll_valid_d;
  logic               roll_illegal_q, roll_illegal_d;
  logic [FACE_W-1:0]  roll_value_q, roll_value_d;
  logic [COUNT_W-1:0] roll_count_q, roll_count_d;

  logic               same;
  logic               dec_legal, dec_blank;
  logic [FACE_W-1:0]  dec_face;

  seg_to_face u_dec (
    .seg   (seg_q),
    .legal (dec_legal),
    .blank (dec_blank),
    .face  (dec_face)
  );

  always_comb begin
    seg_d      = seg;
    seg_prev_d = seg_q;
    same       = (seg_q == seg_prev_q);
    if (!same)                   stab_cnt_d = '0;
    else if (stab_cnt_q == CNT_MAX) stab_cnt_d = stab_cnt_q;
    else                         stab_cnt_d = stab_cnt_q + 1'b1;
  end

  // Settle event: the pattern has been unchanged for STABLE_CYCLES compares.
  always_comb begin
    state_d        = state_q;
    roll_valid_d   = 1'b0;
    roll_illegal_d = 1'b0;
    roll_value_d   = roll_value_q;
    roll_count_d   = roll_count_q;
    case (state_q)
      S_TRACK: begin
        if (same && stab_cnt_q == CNT_SETTLE) begin
          state_d = S_HELD;
          if (dec_legal) begin
            roll_valid_d = 1'b1;
            roll_value_d = dec_face;
            roll_count_d = roll_count_q + COUNT_W'(1);
          end else if (!dec_blank) begin
            roll_illegal_d = 1'b1;
          end
        end
      end
      S_HELD:  if (!same) state_d = S_TRACK;
      default: state_d = S_TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q          <= '0;
      seg_prev_q     <= '0;
      stab_cnt_q     <= '0;
      state_q        <= S_TRACK;
      roll_valid_q   <= 1'b0;
      roll_illegal_q <= 1'b0;
      roll_value_q   <= '0;
      roll_count_q   <= '0;
    end else begin
      seg_q          <= seg_d;
      seg_prev_q     <= seg_prev_d;
      stab_cnt_q     <= stab_cnt_d;
      state_q        <= state_d;
      roll_valid_q   <= roll_valid_d;
      roll_illegal_q <= roll_illegal_d;
      roll_value_q   <= roll_value_d;
      roll_count_q   <= roll_count_d;
    end
  end

  assign roll_valid   = roll_valid_q;
  assign roll_illegal = roll_illegal_q;
  assign roll_value   = roll_value_q;
  assign roll_count   = roll_count_q;

`ifdef DICE_HIST_EN
  logic [HIST_W-1:0] hist_q [1:6];
  logic [HIST_W-1:0] hist_d [1:6];
  logic [HIST_W-1:0] face_count_q, face_count_d;

  // Saturating per-face counters; the read port sees pre-update values.
  always_comb begin
    for (int i = 1; i <= 6; i++) begin
      hist_d[i] = hist_q[i];
      if (roll_valid_d && roll_value_d == FACE_W'(i) && hist_q[i] != '1)
        hist_d[i] = hist_q[i] + 1'b1;
    end
    case (face_sel)
      3'd1:    face_count_d = hist_q[1];
      3'd2:    face_count_d = hist_q[2];
      3'd3:    face_count_d = hist_q[3];
      3'd4:    face_count_d = hist_q[4];
      3'd5:    face_count_d = hist_q[5];
      3'd6:    face_count_d = hist_q[6];
      default: face_count_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= 6; i++) hist_q[i] <= '0;
      face_count_q <= '0;
    end else begin
      for (int i = 1; i <= 6; i++) hist_q[i] <= hist_d[i];
      face_count_q <= face_count_d;
    end
  end

  assign face_count = face_count_q;
`else
  logic unused_face_sel;
  assign unused_face_sel = ^face_sel;
  assign face_count      = '0;
`endif

endmodule

// File: tb/tb_dice_seg_monitor.sv
// Randomized bench for dice_seg_monitor: a run-length reference model checked
// every cycle, plus literal checks on latency, values and counts.
module tb_dice_seg_monitor;

  localparam int S      = 8;
  localparam int HIST_W = 16;

  localparam logic [6:0] FACE_TAB [1:6] = '{7'b0000110, 7'b1011011, 7'b1001111,
                                            7'b1100110, 7'b1101101, 7'b1111101};

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        seg;
  logic              roll_valid, roll_illegal;
  logic [2:0]        roll_value;
  logic [15:0]       roll_count;
  logic [2:0]        face_sel;
  logic [HIST_W-1:0] face_count;

  int checks = 0;
  int errors = 0;

  dice_seg_monitor #(.STABLE_CYCLES(S), .COUNT_W(16), .HIST_W(HIST_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg          (seg),
    .roll_valid   (roll_valid),
    .roll_value   (roll_value),
    .roll_illegal (roll_illegal),
    .roll_count   (roll_count),
    .face_sel     (face_sel),
    .face_count   (face_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int face_of(input logic [6:0] s);
    for (int i = 1; i <= 6; i++) if (FACE_TAB[i] == s) return i;
    return 0;
  endfunction

  // Reference model: a pattern reports once, on the edge after it has been
  // sampled S+1 times in a row.
  int          run = 0;
  logic [6:0]  last = '0;
  bit          last_ok = 0;
  bit          started = 0;
  bit          m_valid, m_ill;
  int          m_val, m_cnt, m_fc;
  int          hist [1:6];

  always @(posedge clk) begin
    int f;
    if (rst) begin
      started = 1;
      m_valid = 0; m_ill = 0; m_val = 0; m_cnt = 0; m_fc = 0;
      run = 0; last_ok = 0;
      for (int i = 1; i <= 6; i++) hist[i] = 0;
    end else begin
      m_valid = 0; m_ill = 0;
      if (run == S + 1) begin
        f = face_of(last);
        if (f != 0) begin
          m_valid = 1; m_val = f; m_cnt = (m_cnt + 1) % 65536;
        end else if (last != 7'b0) begin
          m_ill = 1;
        end
      end
`ifdef DICE_HIST_EN
      m_fc = (face_sel >= 1 && face_sel <= 6) ? hist[face_sel] : 0;
      if (m_valid && hist[m_val] < (1 << HIST_W) - 1) hist[m_val]++;
`else
      m_fc = 0;
`endif
      if (last_ok && seg == last) run++;
      else begin run = 1; last = seg; last_ok = 1; end
    end
    #1;
    if (started) begin
      check("roll_valid",   {31'b0, roll_valid},   {31'b0, m_valid});
      check("roll_illegal", {31'b0, roll_illegal}, {31'b0, m_ill});
      check("roll_value",   {29'b0, roll_value},   m_val);
      check("roll_count",   {16'b0, roll_count},   m_cnt);
      check("face_count",   {16'b0, face_count},   m_fc);
    end
  end

  task automatic step(input logic [6:0] s, input logic r);
    @(negedge clk);
    seg = s;
    rst = r;
    @(posedge clk);
    #2;
  endtask

  // Holds s until a report appears; n is the number of edges, -1 on timeout.
  task automatic wait_pulse(input logic [6:0] s, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step(s, 1'b0);
      if (roll_valid || roll_illegal) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, pulses, idx;
    logic [6:0] s, prev;
    rst = 1'b1; seg = FACE_TAB[3]; face_sel = 3'd2;

    // Held face across reset
    repeat (20) step(FACE_TAB[3], 1'b1);
    check("reset_valid", {31'b0, roll_valid}, 0);
    check("reset_value", {29'b0, roll_value}, 0);
    check("reset_count", {16'b0, roll_count}, 0);
    wait_pulse(FACE_TAB[3], n);
    check("t1_latency", n, 10);
    check("t1_value", {29'b0, roll_value}, 3);
    check("t1_count", {16'b0, roll_count}, 1);

    // Rolling: every cycle a different face, then hold 5
    pulses = 0; prev = FACE_TAB[3];
    for (int i = 0; i < 100; i++) begin
      idx = $urandom_range(1, 6);
      s = FACE_TAB[idx];
      if (s == prev) s = FACE_TAB[idx % 6 + 1];
      if (i == 99 && s == FACE_TAB[5]) s = (prev == FACE_TAB[1]) ? FACE_TAB[2] : FACE_TAB[1];
      step(s, 1'b0);
      if (roll_valid || roll_illegal) pulses++;
      prev = s;
    end
    check("roll_no_pulse", pulses, 0);
    wait_pulse(FACE_TAB[5], n);
    check("t2_latency", n, 10);
    check("t2_value", {29'b0, roll_value}, 5);
    check("t2_count", {16'b0, roll_count}, 2);

    // Glitch restarts the count
    repeat (5) step(FACE_TAB[6], 1'b0);
    step(FACE_TAB[1], 1'b0);
    wait_pulse(FACE_TAB[6], n);
    check("t3_latency", n, 10);
    check("t3_value", {29'b0, roll_value}, 6);
    check("t3_count", {16'b0, roll_count}, 3);

    // Illegal pattern
    wait_pulse(7'b1111111, n);
    check("t4_latency", n, 10);
    check("t4_illegal", {31'b0, roll_illegal}, 1);
    check("t4_valid", {31'b0, roll_valid}, 0);
    check("t4_value", {29'b0, roll_value}, 6);
    check("t4_count", {16'b0, roll_count}, 3);

    // Same face twice separated by blank
    wait_pulse(FACE_TAB[2], n);
    check("t5a_latency", n, 10);
    pulses = 0;
    repeat (10) begin
      step(7'b0, 1'b0);
      if (roll_valid || roll_illegal) pulses++;
    end
    check("blank_no_pulse", pulses, 0);
    wait_pulse(FACE_TAB[2], n);
    check("t5b_latency", n, 10);
    check("t5_value", {29'b0, roll_value}, 2);
    check("t5_count", {16'b0, roll_count}, 5);
    face_sel = 3'd2;
    step(FACE_TAB[2], 1'b0);
    step(FACE_TAB[2], 1'b0);
`ifdef DICE_HIST_EN
    check("hist_face2", {16'b0, face_count}, 2);
`else
    check("hist_face2", {16'b0, face_count}, 0);
`endif

    // Reset mid-count
    repeat (7) step(FACE_TAB[4], 1'b0);
    step(FACE_TAB[4], 1'b1);
    check("t6_rst_valid", {31'b0, roll_valid}, 0);
    check("t6_rst_value", {29'b0, roll_value}, 0);
    check("t6_rst_count", {16'b0, roll_count}, 0);
    wait_pulse(FACE_TAB[4], n);
    check("t6_latency", n, 10);
    check("t6_value", {29'b0, roll_value}, 4);
    check("t6_count", {16'b0, roll_count}, 1);

    // Random read selects and random settle lengths
    for (int i = 0; i < 40; i++) begin
      face_sel = 3'($urandom_range(0, 7));
      s = (i % 5 == 0) ? 7'($urandom) : FACE_TAB[$urandom_range(1, 6)];
      repeat ($urandom_range(1, 14)) step(s, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
